// File: rtl/coolgirl_console_detect.sv
// Power-on CIRAM hold sequencer and famiclone wiring classifier.
// Clocked from CPU M2; samples stable PPU reads to spot a tied /A13 pin.
module coolgirl_console_detect #(
    parameter int INIT_CYCLES    = 15,
    parameter int SAMPLES        = 3,
    parameter int THRESHOLD      = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic m2,
    input  logic rst_n,
    input  logic ppu_rd_in,
    input  logic ppu_a13_in,
    input  logic ppu_not_a13_in,
    input  logic redetect,
    output logic hold_low,
    output logic init_done,
    output logic detect_done,
    output logic new_dendy,
    output logic timed_out,
    output logic [$clog2(2*SAMPLES+1)-1:0] mismatch_count
);

    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int SW = $clog2(SAMPLES + 1);
    localparam int MW = $clog2(2*SAMPLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [SW-1:0] SAMP_MAX  = SW'(SAMPLES);
    localparam logic [MW-1:0] MM_MAX    = MW'(2*SAMPLES);
    localparam logic [MW-1:0] MM_THR    = MW'(THRESHOLD);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_DETECT,
        ST_DONE_NEW,
        ST_DONE_ORIG
    } state_t;

    state_t state, state_n;

    logic [IW-1:0] init_cnt, init_cnt_n;
    logic [SW-1:0] lo_cnt, lo_cnt_n;
    logic [SW-1:0] hi_cnt, hi_cnt_n;
    logic [MW-1:0] mm_cnt, mm_cnt_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          tmo_q, tmo_n;

    logic [1:0] rd_sync;
    logic [1:0] a13_sync;
    logic [1:0] na13_sync;
    logic       rd_prev;
    logic       a13_prev;

    logic rd_s;
    logic a13_s;
    logic na13_s;
    logic sample_ok;
    logic is_mismatch;
    logic take_lo;
    logic take_hi;

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            rd_sync   <= '0;
            a13_sync  <= '0;
            na13_sync <= '0;
            rd_prev   <= 1'b0;
            a13_prev  <= 1'b0;
        end else begin
            rd_sync   <= {rd_sync[0], ppu_rd_in};
            a13_sync  <= {a13_sync[0], ppu_a13_in};
            na13_sync <= {na13_sync[0], ppu_not_a13_in};
            rd_prev   <= rd_sync[1];
            a13_prev  <= a13_sync[1];
        end
    end

    assign rd_s   = rd_sync[1];
    assign a13_s  = a13_sync[1];
    assign na13_s = na13_sync[1];

    // A read counts only once /RD has been low two cycles with A13 steady.
    assign sample_ok   = !rd_s && !rd_prev && (a13_s == a13_prev);
    assign is_mismatch = (a13_s == na13_s);
    assign take_lo     = sample_ok && !a13_s && (lo_cnt != SAMP_MAX);
    assign take_hi     = sample_ok &&  a13_s && (hi_cnt != SAMP_MAX);

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= INIT_LAST;
            lo_cnt   <= '0;
            hi_cnt   <= '0;
            mm_cnt   <= '0;
            to_cnt   <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_n;
            init_cnt <= init_cnt_n;
            lo_cnt   <= lo_cnt_n;
            hi_cnt   <= hi_cnt_n;
            mm_cnt   <= mm_cnt_n;
            to_cnt   <= to_cnt_n;
            tmo_q    <= tmo_n;
        end
    end

    always_comb begin
        state_n    = state;
        init_cnt_n = init_cnt;
        lo_cnt_n   = lo_cnt;
        hi_cnt_n   = hi_cnt;
        mm_cnt_n   = mm_cnt;
        to_cnt_n   = to_cnt;
        tmo_n      = tmo_q;

        unique case (state)
            ST_INIT: begin
                if (init_cnt == '0) begin
                    state_n = ST_DETECT;
                end else begin
                    init_cnt_n = init_cnt - 1'b1;
                end
            end
            default: begin
                if (redetect) begin
                    state_n  = ST_DETECT;
                    lo_cnt_n = '0;
                    hi_cnt_n = '0;
                    mm_cnt_n = '0;
                    to_cnt_n = '0;
                    tmo_n    = 1'b0;
                end else if (state == ST_DETECT) begin
                    to_cnt_n = to_cnt + 1'b1;

                    unique case (1'b1)
                        take_lo: lo_cnt_n = lo_cnt + 1'b1;
                        take_hi: hi_cnt_n = hi_cnt + 1'b1;
                        default: ;
                    endcase

                    if ((take_lo || take_hi) && is_mismatch
                        && (mm_cnt != MM_MAX)) begin
                        mm_cnt_n = mm_cnt + 1'b1;
                    end

                    // Mismatch verdict outranks a complete sample set.
                    if (mm_cnt_n >= MM_THR) begin
                        state_n = ST_DONE_NEW;
                    end else if ((lo_cnt_n == SAMP_MAX)
                                 && (hi_cnt_n == SAMP_MAX)) begin
                        state_n = ST_DONE_ORIG;
                    end else if (to_cnt == TO_LAST) begin
                        state_n = ST_DONE_ORIG;
                        tmo_n   = 1'b1;
                    end
                end
            end
        endcase
    end

    assign hold_low       = (state == ST_INIT);
    assign init_done      = (state != ST_INIT);
    assign detect_done    = (state == ST_DONE_NEW) || (state == ST_DONE_ORIG);
    assign new_dendy      = (state == ST_DONE_NEW);
    assign timed_out      = tmo_q;
    assign mismatch_count = mm_cnt;

endmodule

// File: tb/tb_coolgirl_console_detect.sv
// Bench for coolgirl_console_detect: directed steps plus random traffic
// checked against a history-based behavioural model.
module tb_coolgirl_console_detect;

    localparam int INIT = 15;
    localparam int S    = 3;
    localparam int TH   = 3;
    localparam int TO   = 400;
    localparam int MW   = $clog2(2*S+1);

    logic m2 = 1'b0;
    logic rst_n = 1'b0;
    logic rd = 1'b1;
    logic a13 = 1'b0;
    logic na13 = 1'b1;
    logic redet = 1'b0;

    logic hold_low;
    logic init_done;
    logic detect_done;
    logic new_dendy;
    logic timed_out;
    logic [MW-1:0] mismatch_count;

    int total = 0;
    int bad = 0;
    int edge_no = 0;

    // phase: 0 init, 1 detect, 2 done-new, 3 done-orig
    int m_phase, m_init, m_lo, m_hi, m_mm, m_det, m_tmo;
    int h_rd[$];
    int h_a[$];
    int h_na[$];

    coolgirl_console_detect #(
        .INIT_CYCLES(INIT),
        .SAMPLES(S),
        .THRESHOLD(TH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .m2(m2),
        .rst_n(rst_n),
        .ppu_rd_in(rd),
        .ppu_a13_in(a13),
        .ppu_not_a13_in(na13),
        .redetect(redet),
        .hold_low(hold_low),
        .init_done(init_done),
        .detect_done(detect_done),
        .new_dendy(new_dendy),
        .timed_out(timed_out),
        .mismatch_count(mismatch_count)
    );

    always #5 m2 = ~m2;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_init = 0; m_lo = 0; m_hi = 0;
        m_mm = 0; m_det = 0; m_tmo = 0;
        h_rd = '{0, 0, 0, 0};
        h_a  = '{0, 0, 0, 0};
        h_na = '{0, 0, 0, 0};
    endtask

    // Inputs reach the logic two edges late; index 2 is "now", 3 is "before".
    task automatic model_edge();
        int rd2, rd3, a2, a3, na2;
        bit v;
        h_rd.push_front(int'(rd));
        h_a.push_front(int'(a13));
        h_na.push_front(int'(na13));
        void'(h_rd.pop_back());
        void'(h_a.pop_back());
        void'(h_na.pop_back());
        rd2 = h_rd[2]; rd3 = h_rd[3];
        a2 = h_a[2]; a3 = h_a[3]; na2 = h_na[2];
        if (m_phase == 0) begin
            m_init++;
            if (m_init == INIT) m_phase = 1;
        end else if (redet) begin
            m_lo = 0; m_hi = 0; m_mm = 0; m_det = 0; m_tmo = 0;
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_det++;
            v = (rd2 == 0) && (rd3 == 0) && (a2 == a3);
            if (v && a2 == 0 && m_lo < S) begin
                m_lo++;
                if (a2 == na2) m_mm++;
            end else if (v && a2 == 1 && m_hi < S) begin
                m_hi++;
                if (a2 == na2) m_mm++;
            end
            if (m_mm >= TH) m_phase = 2;
            else if (m_lo == S && m_hi == S) m_phase = 3;
            else if (m_det == TO) begin
                m_phase = 3;
                m_tmo = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".hold_low"}, hold_low, m_phase == 0);
        chk({tag, ".init_done"}, init_done, m_phase != 0);
        chk({tag, ".detect_done"}, detect_done, m_phase >= 2);
        chk({tag, ".new_dendy"}, new_dendy, m_phase == 2);
        chk({tag, ".timed_out"}, timed_out, m_tmo);
        chk({tag, ".mismatch_count"}, mismatch_count, m_mm);
    endtask

    task automatic tick();
        @(posedge m2);
        edge_no++;
        model_edge();
        @(negedge m2);
        check_all("cyc");
    endtask

    task automatic idle(input int n);
        rd = 1'b1;
        repeat (n) tick();
    endtask

    task automatic rd_cycle(input logic a, input logic na);
        a13 = a;
        na13 = na;
        rd = 1'b0;
        tick();
        tick();
        rd = 1'b1;
        tick();
    endtask

    task automatic pulse_redet();
        redet = 1'b1;
        tick();
        redet = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst.hold_low", hold_low, 1);
        chk("rst.init_done", init_done, 0);
        chk("rst.detect_done", detect_done, 0);
        chk("rst.new_dendy", new_dendy, 0);
        chk("rst.timed_out", timed_out, 0);
        chk("rst.mismatch_count", mismatch_count, 0);
        model_reset();
        edge_no = 0;
        @(negedge m2);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge m2);
        do_reset();

        // power-on hold then timeout with an idle PPU
        rd = 1'b1;
        repeat (INIT-1) tick();
        chk("t1.hold_e14", hold_low, 1);
        chk("t1.init_e14", init_done, 0);
        tick();
        chk("t1.hold_e15", hold_low, 0);
        chk("t1.init_e15", init_done, 1);
        repeat (TO-1) tick();
        chk("t1.not_done_early", detect_done, 0);
        tick();
        chk("t1.edge", edge_no, INIT+TO);
        chk("t1.timed_out", timed_out, 1);
        chk("t1.done", detect_done, 1);
        chk("t1.new", new_dendy, 0);

        // correct wiring
        pulse_redet();
        chk("t2.cleared", timed_out, 0);
        for (int i = 0; i < S; i++) begin
            rd_cycle(1'b0, 1'b1);
            rd_cycle(1'b1, 1'b0);
        end
        idle(3);
        chk("t2.done", detect_done, 1);
        chk("t2.new", new_dendy, 0);
        chk("t2.mm", mismatch_count, 0);

        // clone wiring
        pulse_redet();
        rd_cycle(1'b0, 1'b0);
        rd_cycle(1'b1, 1'b1);
        idle(2);
        chk("t3.mm2", mismatch_count, 2);
        chk("t3.not_done", detect_done, 0);
        rd_cycle(1'b0, 1'b0);
        idle(2);
        chk("t3.new", new_dendy, 1);
        chk("t3.mm3", mismatch_count, 3);

        // redetect out of DONE_NEW with correct wiring
        pulse_redet();
        chk("t6.flags_clear", new_dendy, 0);
        chk("t6.no_reinit", hold_low, 0);
        for (int i = 0; i < S; i++) begin
            rd_cycle(1'b0, 1'b1);
            rd_cycle(1'b1, 1'b0);
        end
        idle(3);
        chk("t6.orig", detect_done, 1);
        chk("t6.orig_new", new_dendy, 0);

        // two mismatches below threshold
        pulse_redet();
        rd_cycle(1'b0, 1'b0);
        rd_cycle(1'b1, 1'b0);
        rd_cycle(1'b0, 1'b1);
        rd_cycle(1'b1, 1'b1);
        rd_cycle(1'b0, 1'b1);
        rd_cycle(1'b1, 1'b0);
        idle(3);
        chk("t4.orig", detect_done, 1);
        chk("t4.orig_new", new_dendy, 0);
        chk("t4.mm2", mismatch_count, 2);

        // saturated-bucket samples ignored, then mismatch wins at completion
        pulse_redet();
        for (int i = 0; i < S; i++) rd_cycle(1'b0, 1'b1);
        rd_cycle(1'b0, 1'b0);
        rd_cycle(1'b1, 1'b1);
        rd_cycle(1'b1, 1'b1);
        idle(2);
        chk("t4.sat_mm", mismatch_count, 2);
        rd_cycle(1'b1, 1'b1);
        idle(2);
        chk("t4.new", new_dendy, 1);

        // glitch rejection with tied pins
        pulse_redet();
        a13 = 1'b0;
        na13 = 1'b0;
        repeat (4) begin
            rd = 1'b0;
            tick();
            rd = 1'b1;
            tick();
        end
        rd = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a13 = i[0];
            na13 = i[0];
            tick();
        end
        idle(3);
        chk("t5.mm", mismatch_count, 0);
        chk("t5.done", detect_done, 0);

        // reset mid-detection repeats the hold
        pulse_redet();
        rd_cycle(1'b0, 1'b1);
        do_reset();
        redet = 1'b1;
        tick();
        redet = 1'b0;
        repeat (INIT-2) tick();
        chk("t6.rehold_e14", hold_low, 1);
        tick();
        chk("t6.rehold_e15", hold_low, 0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rd = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) a13 = ~a13;
            na13 = ($urandom_range(0, 5) == 0) ? a13 : ~a13;
            redet = ($urandom_range(0, 59) == 0);
            tick();
        end
        redet = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
